// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - nibble-serial add/subtract sequencer driving one shared 4-bit slice (flags: NIBBLE_SEQ_FLAGS_EN)
module nibble_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [CW+1:0]    w_lsb;

    // bit offset of the nibble currently on the slice
    assign w_lsb = {r_cnt, 2'b00};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state, slice drive and handshake outputs
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        add_a    = 4'd0;
        add_b    = 4'd0;
        add_cin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                w_step  = 1'b1;
                add_a   = r_a[w_lsb +: 4];
                add_b   = r_b[w_lsb +: 4];
                add_cin = r_carry;
                w_last  = (r_cnt == LAST_CNT);
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // operand capture and nibble-by-nibble result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            // subtraction is A + ~B + 1: invert B once here, seed carry with 1
            r_a      <= op_a;
            r_b      <= op_b ^ {WIDTH{sub}};
            r_carry  <= sub;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_step) begin
            r_result[w_lsb +: 4] <= add_s;
            r_carry              <= add_cout;
            r_cnt                <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= add_cout;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;

`ifdef NIBBLE_SEQ_FLAGS_EN
    logic r_ovf;
    logic r_zero;

    // flags latched on the final nibble, using the top nibble straight from the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_step && w_last) begin
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_s[3] != r_a[WIDTH-1]);
            r_zero <= (add_s == 4'd0) && (r_result[WIDTH-5:0] == '0);
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - scoreboard bench for nibble_add_seq with a behavioural 4-bit slice
module tb_nibble_add_seq;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [3:0]       add_a, add_b, add_s;
    logic             add_cin, add_cout;
    logic             busy, done, cout, ovf, zero;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             ov;
        logic             z;
        int               done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_seen = 0;
    logic [WIDTH-1:0] last_r = '0;
    logic             last_c = 1'b0;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .busy(busy), .done(done), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero)
    );

    // the shared 4-bit ripple slice, modelled as plain addition
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // reference: ordinary two's-complement arithmetic on the whole word
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t   e;
        longint sa, sb, ex;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ex = s ? (sa - sb) : (sa + sb);
        e.r = s ? (a - b) : (a + b);
        e.c = s ? (a >= b) : ((longint'(a) + longint'(b)) > longint'(32'hFFFF_FFFF));
`ifdef NIBBLE_SEQ_FLAGS_EN
        e.ov = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        e.z  = (e.r == '0);
`else
        e.ov = 1'b0;
        e.z  = 1'b0;
`endif
        e.done_cyc = 0;
        return e;
    endfunction

    // monitor: every done pulse pops and checks one expected response
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",  64'(result), 64'(e.r));
                check("cout",    64'(cout),   64'(e.c));
                check("ovf",     64'(ovf),    64'(e.ov));
                check("zero",    64'(zero),   64'(e.z));
                check("latency", 64'(cyc),    64'(e.done_cyc));
                check("slice_idle_in_done", 64'({add_a, add_b, add_cin}), 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idle_timeout", 64'd1, 64'd0);
    endtask

    // issue one operation at the next idle negedge; returns with start low again
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        wait_idle();
        e = model(a, b, s);
        e.done_cyc = cyc + 1 + NIB;
        exp_q.push_back(e);
        last_r = e.r;
        last_c = e.c;
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags",  64'({cout, ovf, zero}), 64'd0);
        check("rst_slice",  64'({add_a, add_b, add_cin}), 64'd0);
        rst_n = 1'b1;

        // directed corner cases
        issue(32'h0000_0001, 32'h0000_000F, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'd5, 32'd7, 1'b1);
        issue(32'd7, 32'd5, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_idle();

        // result and cout hold through idle cycles
        repeat (5) @(negedge clk);
        check("hold_result", 64'(result), 64'(last_r));
        check("hold_cout",   64'(cout),   64'(last_c));

        // starts while busy are ignored
        d0 = done_seen;
        issue(32'h0000_1111, 32'h0000_2222, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
        wait_idle();
        check("busy_start_one_done", 64'(done_seen - d0), 64'd1);

        // start during the DONE cycle is ignored
        issue(32'h0000_00AA, 32'h0000_0055, 1'b0);
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("done_seen_for_done_start", 64'(done), 64'd1);
        end
        op_a = 32'hDEAD_BEEF; op_b = 32'h1; sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_ignored", 64'(busy), 64'd0);
        check("done_start_result",  64'(result), 64'(32'h0000_00FF));

        // asynchronous reset in the 4th RUN cycle aborts the operation
        issue(32'hCAFE_0000, 32'h0000_BABE, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   64'(busy),   64'd0);
        check("abort_done",   64'(done),   64'd0);
        check("abort_result", 64'(result), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0003, 32'h0000_0004, 1'b0);

        // randomized operations, with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(a, b, 1'($urandom));
        end
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
